// File: rtl/alu_pwr_pkg.sv
// Shared definitions for the PD_ALU power sequencer.
//   pwr_state_e : state encoding, also exported on the pwr_state port
//   *_DEF       : default timing constants for the sequencer parameters
//   pwr_ctl_t   : power-control output bundle {pwr_en, iso_en, save, restore}
//   ctl_of()    : Moore decode from state to the power-control bundle
package alu_pwr_pkg;

  typedef enum logic [2:0] {
    PS_ON      = 3'd0,
    PS_DRAIN   = 3'd1,
    PS_SAVE    = 3'd2,
    PS_ISO     = 3'd3,
    PS_OFF     = 3'd4,
    PS_PWRUP   = 3'd5,
    PS_RESTORE = 3'd6,
    PS_UNISO   = 3'd7
  } pwr_state_e;

  localparam int ISO_SETUP_CYC_DEF = 2;
  localparam int PWRUP_CYC_DEF     = 4;
  localparam int IDLE_TIMEOUT_DEF  = 16;
  localparam int CNT_W_DEF         = 16;

  typedef struct packed {
    logic pwr_en;
    logic iso_en;
    logic save;
    logic restore;
  } pwr_ctl_t;

  // Every state keeps iso_en high whenever pwr_en is low, so the decoded
  // bundle can never expose an unisolated, unpowered domain.
  function automatic pwr_ctl_t ctl_of(input pwr_state_e s);
    pwr_ctl_t c;
    c = '{pwr_en: 1'b1, iso_en: 1'b0, save: 1'b0, restore: 1'b0};
    case (s)
      PS_ON:      c = '{pwr_en: 1'b1, iso_en: 1'b0, save: 1'b0, restore: 1'b0};
      PS_DRAIN:   c = '{pwr_en: 1'b1, iso_en: 1'b0, save: 1'b0, restore: 1'b0};
      PS_SAVE:    c = '{pwr_en: 1'b1, iso_en: 1'b0, save: 1'b1, restore: 1'b0};
      PS_ISO:     c = '{pwr_en: 1'b1, iso_en: 1'b1, save: 1'b0, restore: 1'b0};
      PS_OFF:     c = '{pwr_en: 1'b0, iso_en: 1'b1, save: 1'b0, restore: 1'b0};
      PS_PWRUP:   c = '{pwr_en: 1'b1, iso_en: 1'b1, save: 1'b0, restore: 1'b0};
      PS_RESTORE: c = '{pwr_en: 1'b1, iso_en: 1'b1, save: 1'b0, restore: 1'b1};
      PS_UNISO:   c = '{pwr_en: 1'b1, iso_en: 1'b0, save: 1'b0, restore: 1'b0};
      default:    c = '{pwr_en: 1'b1, iso_en: 1'b0, save: 1'b0, restore: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_pwr_timer.sv
// Loadable down-counter with a done flag, used for the fixed-length
// sequencer dwell times (isolation setup and power-up settle).
//   clk      : clock
//   rst      : synchronous active-high reset, counter to 0
//   load     : load load_val this cycle (has priority over counting)
//   load_val : value to load; the wait lasts load_val+1 cycles
//   done     : counter is at 0
module alu_pwr_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// Power-management sequencer for the ALU power domain (PD_ALU).
// Orders alu_pwr_en / iso_en / save / restore glitch-free, gates ALU
// starts during transitions and can auto-sleep after an idle period.
//   clk, rst       : clock, synchronous active-high reset (returns to ON)
//   sleep_req      : level request to power down
//   wake_req       : level request to power up
//   auto_sleep_en  : enables the idle-timeout sleep
//   start_in       : requester's ALU start
//   alu_busy       : ALU has a multi-cycle op in flight
//   start_out      : start forwarded to the ALU (only in ON, no sleep trigger)
//   alu_pwr_en     : PD_ALU power enable (registered)
//   iso_en         : isolation enable (registered)
//   save, restore  : one-cycle retention strobes (registered)
//   sleep_ack      : pulse in the first OFF cycle
//   wake_ack       : pulse in the first ON cycle after a wake sequence
//   pwr_state      : current state encoding
module alu_pwr_seq
  import alu_pwr_pkg::*;
#(
  parameter int ISO_SETUP_CYC = ISO_SETUP_CYC_DEF,
  parameter int PWRUP_CYC     = PWRUP_CYC_DEF,
  parameter int IDLE_TIMEOUT  = IDLE_TIMEOUT_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       auto_sleep_en,
  input  logic       start_in,
  input  logic       alu_busy,
  output logic       start_out,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       sleep_ack,
  output logic       wake_ack,
  output logic [2:0] pwr_state
);

  localparam logic [CNT_W-1:0] ISO_LOAD   = CNT_W'(ISO_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_TIMEOUT - 1);

  pwr_state_e       state;
  pwr_state_e       state_nxt;
  logic [CNT_W-1:0] idle_cnt;
  logic             wake_pending;
  logic             idle_now;
  logic             idle_trig;
  logic             sleep_trig;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  alu_pwr_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // A cycle only counts as idle when nothing is issued or in flight; a start
  // arriving on the timeout cycle therefore wins over auto-sleep.
  assign idle_now   = auto_sleep_en && !start_in && !alu_busy;
  assign idle_trig  = idle_now && (idle_cnt == IDLE_LAST);
  // wake_req in ON suppresses any sleep trigger (wake has priority).
  assign sleep_trig = (state == PS_ON) && !wake_req && (sleep_req || idle_trig);
  assign start_out  = start_in && (state == PS_ON) && !sleep_trig;
  assign pwr_state  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      PS_ON:      if (sleep_trig) state_nxt = PS_DRAIN;
      PS_DRAIN:   if (!alu_busy && !start_in) state_nxt = PS_SAVE;
      PS_SAVE:    state_nxt = PS_ISO;
      PS_ISO:     if (tmr_done) state_nxt = PS_OFF;
      PS_OFF:     if (wake_req || wake_pending) state_nxt = PS_PWRUP;
      PS_PWRUP:   if (tmr_done) state_nxt = PS_RESTORE;
      PS_RESTORE: state_nxt = PS_UNISO;
      PS_UNISO:   state_nxt = PS_ON;
      default:    state_nxt = PS_ON;
    endcase
  end

  // The timer is armed on the edge that enters ISO or PWRUP so that its
  // done flag rises in the last cycle of that state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PWRUP_LOAD;
    if (state == PS_SAVE) begin
      tmr_load = 1'b1;
      tmr_val  = ISO_LOAD;
    end else if ((state == PS_OFF) && (state_nxt == PS_PWRUP)) begin
      tmr_load = 1'b1;
      tmr_val  = PWRUP_LOAD;
    end
  end

  // Outputs are registered from the next-state decode, so they always equal
  // ctl_of(state) without any combinational glitch on the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PS_ON;
      alu_pwr_en   <= 1'b1;
      iso_en       <= 1'b0;
      save         <= 1'b0;
      restore      <= 1'b0;
      sleep_ack    <= 1'b0;
      wake_ack     <= 1'b0;
      wake_pending <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      state                               <= state_nxt;
      {alu_pwr_en, iso_en, save, restore} <= ctl_of(state_nxt);
      sleep_ack <= (state == PS_ISO) && (state_nxt == PS_OFF);
      wake_ack  <= (state == PS_UNISO);

      // A wake arriving mid-sleep is remembered and served after one OFF cycle.
      if ((state == PS_OFF) && (state_nxt == PS_PWRUP)) begin
        wake_pending <= 1'b0;
      end else if (wake_req && ((state == PS_DRAIN) || (state == PS_SAVE) ||
                                (state == PS_ISO))) begin
        wake_pending <= 1'b1;
      end

      if ((state != PS_ON) || (state_nxt != PS_ON) || !idle_now) begin
        idle_cnt <= '0;
      end else if (idle_cnt != '1) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
    end
  end

endmodule
